ahci_xfer_cntr: RTL and testbench

Data-transfer byte/DWORD accounting stage for AHCI port 0, directly downstream of the port state machine. It consumes the state machine's `decr_dwc`/`decr_DXC_dw`, `update_prdbc` and command-start strobes, plus the transfer counts parsed from DMA Setup and PIO Setup FISes. It produces `xfer_cntr`/`xfer_cntr_zero` back to the state machine and writes the PRD Byte Count (PRDBC) into the active command header in register memory. Output register-port signals are zero when idle, so they can be OR-muxed with the other register-memory masters.

---
 rtl/ahci_xfer_cntr_pkg.sv | 15 +
 rtl/ahci_xfer_cntr.sv | 111 +++++++++++
 tb/tb_ahci_xfer_cntr.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ahci_xfer_cntr_pkg.sv
// Shared constants and helpers for the AHCI transfer-count accounting stage.
package ahci_xfer_cntr_pkg;

  localparam int unsigned CMD_HDR_DW    = 8;
  localparam int unsigned PRDBC_DW_OFFS = 1;
  localparam int unsigned DW_CNT_W      = 30;

  // Byte count to DWORD count, rounding up; the carry out of bit 31 is dropped.
  function automatic logic [DW_CNT_W-1:0] bytes_to_dw(input logic [31:0] bytes);
    logic [32:0] sum;
    sum = 33'(bytes) + 33'd3;
    return DW_CNT_W'(sum >> 2);
  endfunction

endpackage

// File: rtl/ahci_xfer_cntr.sv
// Remaining-DWORD counter, PRD byte count accumulator and PRDBC write-back to
// the command header in register memory.
module ahci_xfer_cntr
  import ahci_xfer_cntr_pkg::*;
#(
  parameter int unsigned ADDRESS_BITS = 10,
  parameter int unsigned CLB_OFFS     = 'h200
) (
  input  logic                    mclk,
  input  logic                    hba_rst,
  input  logic                    cmd_start,
  input  logic [4:0]              cmd_slot,
  input  logic                    load_dma,
  input  logic [31:0]             dma_cnt,
  input  logic                    load_pio,
  input  logic [15:0]             pio_cnt,
  input  logic                    decr_dwc,
  input  logic [11:0]             decr_DXC_dw,
  input  logic                    update_prdbc,
  output logic [31:2]             xfer_cntr,
  output logic                    xfer_cntr_zero,
  output logic                    xfer_underflow,
  output logic [31:0]             prdbc,
  output logic [ADDRESS_BITS-1:0] regs_addr,
  output logic                    regs_we,
  output logic [31:0]             regs_din
);

  logic [DW_CNT_W-1:0]     cntr_q, cntr_d;
  logic                    zero_q;
  logic                    und_q, und_d;
  logic [31:0]             prdbc_q, prdbc_d;
  logic [4:0]              slot_q, slot_d;
  logic                    wr1_q;
  logic [ADDRESS_BITS-1:0] addr1_q;
  logic [31:0]             data1_q;
  logic                    we_q;
  logic [ADDRESS_BITS-1:0] addr_q;
  logic [31:0]             din_q;
  logic [ADDRESS_BITS-1:0] wr_addr_c;

  // Counter next state: decrement, then loads, then command start on top.
  always_comb begin
    cntr_d  = cntr_q;
    und_d   = und_q;
    prdbc_d = prdbc_q;
    slot_d  = slot_q;
    if (decr_dwc) begin
      if (DW_CNT_W'(decr_DXC_dw) > cntr_q) begin
        cntr_d = '0;
        und_d  = 1'b1;
      end else begin
        cntr_d = cntr_q - DW_CNT_W'(decr_DXC_dw);
      end
      prdbc_d = prdbc_q + {18'd0, decr_DXC_dw, 2'b00};
    end
    if (load_dma) begin
      cntr_d = bytes_to_dw(dma_cnt);
      und_d  = 1'b0;
    end else if (load_pio) begin
      cntr_d = bytes_to_dw(32'(pio_cnt));
      und_d  = 1'b0;
    end
    if (cmd_start) begin
      cntr_d  = '0;
      und_d   = 1'b0;
      prdbc_d = '0;
      slot_d  = cmd_slot;
    end
  end

  assign wr_addr_c = ADDRESS_BITS'(CLB_OFFS + 32'(slot_d) * CMD_HDR_DW + PRDBC_DW_OFFS);

  // Counters plus the two-stage write pipe; idle write outputs are forced to 0.
  always_ff @(posedge mclk) begin
    if (hba_rst) begin
      cntr_q  <= '0;
      zero_q  <= 1'b1;
      und_q   <= 1'b0;
      prdbc_q <= '0;
      slot_q  <= '0;
      wr1_q   <= 1'b0;
      addr1_q <= '0;
      data1_q <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      din_q   <= '0;
    end else begin
      cntr_q  <= cntr_d;
      zero_q  <= (cntr_d == '0);
      und_q   <= und_d;
      prdbc_q <= prdbc_d;
      slot_q  <= slot_d;
      wr1_q   <= update_prdbc;
      addr1_q <= update_prdbc ? wr_addr_c : '0;
      data1_q <= update_prdbc ? prdbc_d : '0;
      we_q    <= wr1_q;
      addr_q  <= wr1_q ? addr1_q : '0;
      din_q   <= wr1_q ? data1_q : '0;
    end
  end

  assign xfer_cntr      = cntr_q;
  assign xfer_cntr_zero = zero_q;
  assign xfer_underflow = und_q;
  assign prdbc          = prdbc_q;
  assign regs_addr      = addr_q;
  assign regs_we        = we_q;
  assign regs_din       = din_q;

endmodule

// File: tb/tb_ahci_xfer_cntr.sv
// Directed bench for ahci_xfer_cntr with a cycle-level reference model.
module tb_ahci_xfer_cntr;

  localparam int S_XFER = 0, S_ZERO = 1, S_UND = 2, S_PRDBC = 3,
                 S_WE = 4, S_ADDR = 5, S_DIN = 6;

  logic        mclk = 1'b0;
  logic        hba_rst = 1'b1;
  logic        cmd_start = 1'b0;
  logic [4:0]  cmd_slot = '0;
  logic        load_dma = 1'b0;
  logic [31:0] dma_cnt = '0;
  logic        load_pio = 1'b0;
  logic [15:0] pio_cnt = '0;
  logic        decr_dwc = 1'b0;
  logic [11:0] decr_DXC_dw = '0;
  logic        update_prdbc = 1'b0;
  logic [31:2] xfer_cntr;
  logic        xfer_cntr_zero;
  logic        xfer_underflow;
  logic [31:0] prdbc;
  logic [9:0]  regs_addr;
  logic        regs_we;
  logic [31:0] regs_din;

  ahci_xfer_cntr #(.ADDRESS_BITS(10), .CLB_OFFS('h200)) dut (
    .mclk(mclk), .hba_rst(hba_rst), .cmd_start(cmd_start), .cmd_slot(cmd_slot),
    .load_dma(load_dma), .dma_cnt(dma_cnt), .load_pio(load_pio), .pio_cnt(pio_cnt),
    .decr_dwc(decr_dwc), .decr_DXC_dw(decr_DXC_dw), .update_prdbc(update_prdbc),
    .xfer_cntr(xfer_cntr), .xfer_cntr_zero(xfer_cntr_zero),
    .xfer_underflow(xfer_underflow), .prdbc(prdbc), .regs_addr(regs_addr),
    .regs_we(regs_we), .regs_din(regs_din)
  );

  always #5 mclk = ~mclk;

  typedef struct {
    int     due;
    longint addr;
    longint data;
  } wr_t;

  // Reference model state
  int     cyc = 0;
  longint m_cntr = 0;
  longint m_prdbc = 0;
  longint m_und = 0;
  longint m_slot = 0;
  wr_t    wq[$];

  // Literal expectations queued by the stimulus, consumed by the compare process
  string  lit_name[128];
  int     lit_sig[128];
  longint lit_exp[128];
  int     lit_n = 0;
  int     lit_rd = 0;

  int checks = 0;
  int failures = 0;

  always @(posedge mclk) begin : model
    longint c, p, u, sl;
    wr_t w;
    c = m_cntr; p = m_prdbc; u = m_und; sl = m_slot;
    while (wq.size() > 0 && wq[0].due <= cyc) void'(wq.pop_front());
    if (hba_rst) begin
      c = 0; p = 0; u = 0; sl = 0;
      wq.delete();
    end else begin
      if (cmd_start) begin
        c = 0; p = 0; u = 0; sl = longint'(cmd_slot);
      end else begin
        if (decr_dwc) begin
          p = (p + 4 * longint'(decr_DXC_dw)) % 64'h1_0000_0000;
          if (longint'(decr_DXC_dw) > c) begin
            c = 0; u = 1;
          end else begin
            c = c - longint'(decr_DXC_dw);
          end
        end
        if (load_dma) begin
          c = ((longint'(dma_cnt) + 3) / 4) % 64'h4000_0000; u = 0;
        end else if (load_pio) begin
          c = (longint'(pio_cnt) + 3) / 4; u = 0;
        end
      end
      if (update_prdbc) begin
        w.due = cyc + 2;
        w.addr = 'h200 + sl * 8 + 1;
        w.data = p;
        wq.push_back(w);
      end
    end
    m_cntr  <= c;
    m_prdbc <= p;
    m_und   <= u;
    m_slot  <= sl;
    cyc     <= cyc + 1;
  end

  function automatic longint sig_val(int s);
    case (s)
      S_XFER:  return longint'(xfer_cntr);
      S_ZERO:  return longint'(xfer_cntr_zero);
      S_UND:   return longint'(xfer_underflow);
      S_PRDBC: return longint'(prdbc);
      S_WE:    return longint'(regs_we);
      S_ADDR:  return longint'(regs_addr);
      default: return longint'(regs_din);
    endcase
  endfunction

  task automatic chk(string nm, longint act, longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d actual=0x%0h expected=0x%0h", nm, cyc, act, exp);
    end
  endtask

  always @(negedge mclk) begin : compare
    longint e_we, e_addr, e_din;
    if (cyc > 0) begin
      e_we = 0; e_addr = 0; e_din = 0;
      foreach (wq[i]) if (wq[i].due == cyc) begin
        e_we = 1; e_addr = wq[i].addr; e_din = wq[i].data;
      end
      chk("model_xfer_cntr", sig_val(S_XFER), m_cntr);
      chk("model_xfer_cntr_zero", sig_val(S_ZERO), (m_cntr == 0) ? 1 : 0);
      chk("model_xfer_underflow", sig_val(S_UND), m_und);
      chk("model_prdbc", sig_val(S_PRDBC), m_prdbc);
      chk("model_regs_we", sig_val(S_WE), e_we);
      chk("model_regs_addr", sig_val(S_ADDR), e_addr);
      chk("model_regs_din", sig_val(S_DIN), e_din);
      while (lit_rd < lit_n) begin
        chk(lit_name[lit_rd], sig_val(lit_sig[lit_rd]), lit_exp[lit_rd]);
        lit_rd++;
      end
    end
  end

  task automatic idle();
    cmd_start = 0; load_dma = 0; load_pio = 0; decr_dwc = 0; update_prdbc = 0;
  endtask

  task automatic tick();
    @(posedge mclk);
    #1;
    idle();
  endtask

  task automatic lit(string nm, int s, longint v);
    lit_name[lit_n] = nm;
    lit_sig[lit_n]  = s;
    lit_exp[lit_n]  = v;
    lit_n++;
  endtask

  task automatic settle();
    @(negedge mclk);
    #1;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin : stim
    idle();
    repeat (2) @(posedge mclk);
    #1 hba_rst = 0;
    lit("rst_xfer", S_XFER, 0); lit("rst_zero", S_ZERO, 1); lit("rst_und", S_UND, 0);
    lit("rst_prdbc", S_PRDBC, 0); lit("rst_we", S_WE, 0);
    settle();

    // Load rounding and exact-boundary decrements
    cmd_start = 1; cmd_slot = 0; tick();
    load_dma = 1; dma_cnt = 8193; tick();
    lit("dma8193_xfer", S_XFER, 2049); lit("dma8193_zero", S_ZERO, 0); settle();
    decr_dwc = 1; decr_DXC_dw = 2048; tick();
    lit("dec2048_xfer", S_XFER, 1); lit("dec2048_prdbc", S_PRDBC, 8192); settle();
    decr_dwc = 1; decr_DXC_dw = 1; tick();
    lit("dec1_xfer", S_XFER, 0); lit("dec1_zero", S_ZERO, 1); lit("dec1_prdbc", S_PRDBC, 8196);
    settle();

    // Write latency and slot addressing
    cmd_start = 1; cmd_slot = 5; tick();
    update_prdbc = 1; tick();
    lit("wr_t1_we", S_WE, 0); settle();
    tick();
    lit("wr_t2_we", S_WE, 1); lit("wr_t2_addr", S_ADDR, 'h229); lit("wr_t2_din", S_DIN, 0);
    settle();
    tick();
    lit("wr_t3_we", S_WE, 0); lit("wr_t3_addr", S_ADDR, 0); settle();

    // Same-cycle decrement is visible in written data
    decr_dwc = 1; decr_DXC_dw = 100; tick();
    lit("pre_prdbc", S_PRDBC, 400); settle();
    decr_dwc = 1; decr_DXC_dw = 100; update_prdbc = 1; tick();
    lit("same_prdbc", S_PRDBC, 800); settle();
    tick();
    lit("same_we", S_WE, 1); lit("same_din", S_DIN, 800); lit("same_addr", S_ADDR, 'h229);
    settle();

    // Underflow on PIO count, cleared by next load
    cmd_start = 1; cmd_slot = 5; tick();
    load_pio = 1; pio_cnt = 512; tick();
    lit("pio_xfer", S_XFER, 128); settle();
    decr_dwc = 1; decr_DXC_dw = 200; tick();
    lit("uf_xfer", S_XFER, 0); lit("uf_und", S_UND, 1); lit("uf_prdbc", S_PRDBC, 800); settle();
    load_pio = 1; pio_cnt = 512; tick();
    lit("pio2_und", S_UND, 0); lit("pio2_xfer", S_XFER, 128); settle();

    // Load wins over decrement for the counter, prdbc still accumulates
    load_dma = 1; dma_cnt = 40; decr_dwc = 1; decr_DXC_dw = 3; tick();
    lit("ld_dec_xfer", S_XFER, 10); lit("ld_dec_prdbc", S_PRDBC, 812); settle();
    load_dma = 1; dma_cnt = 8; load_pio = 1; pio_cnt = 400; tick();
    lit("dma_wins_xfer", S_XFER, 2); settle();

    // Maximum DMA counts
    load_dma = 1; dma_cnt = 32'hFFFF_FFFF; tick();
    lit("dmamax_xfer", S_XFER, 0); lit("dmamax_zero", S_ZERO, 1); settle();
    decr_dwc = 1; decr_DXC_dw = 1; tick();
    lit("dmamax_und", S_UND, 1); settle();
    load_dma = 1; dma_cnt = 32'hFFFF_FFFC; tick();
    lit("dmafc_xfer", S_XFER, 'h3FFF_FFFF); settle();
    decr_dwc = 1; decr_DXC_dw = 2048; tick();
    lit("dmafc_dec", S_XFER, 'h3FFF_F7FF); settle();

    // cmd_start overrides everything; back-to-back writes
    cmd_start = 1; cmd_slot = 3; load_dma = 1; dma_cnt = 100; decr_dwc = 1; decr_DXC_dw = 10;
    tick();
    lit("cs_xfer", S_XFER, 0); lit("cs_prdbc", S_PRDBC, 0); lit("cs_und", S_UND, 0); settle();
    decr_dwc = 1; decr_DXC_dw = 7; tick();
    update_prdbc = 1; tick();
    update_prdbc = 1; decr_dwc = 1; decr_DXC_dw = 1; tick();
    lit("b2b_we0", S_WE, 1); lit("b2b_addr0", S_ADDR, 'h219); lit("b2b_din0", S_DIN, 28); settle();
    tick();
    lit("b2b_we1", S_WE, 1); lit("b2b_din1", S_DIN, 32); settle();
    tick();
    lit("b2b_end_we", S_WE, 0); settle();

    // Reset flushes a pending write
    load_dma = 1; dma_cnt = 40; tick();
    update_prdbc = 1; tick();
    hba_rst = 1; tick();
    hba_rst = 0;
    lit("rst2_we", S_WE, 0); lit("rst2_xfer", S_XFER, 0); lit("rst2_zero", S_ZERO, 1);
    lit("rst2_prdbc", S_PRDBC, 0); lit("rst2_und", S_UND, 0); lit("rst2_din", S_DIN, 0);
    settle();
    tick();
    lit("rst2_t3_we", S_WE, 0); settle();
    repeat (2) tick();
    settle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
